// File: rtl/i2c_cmd_arbiter_if.sv
// Bundle of every signal between the command arbiter, its requesters and the I2C byte master.
// Latency: none, wires only.
// Backpressure: requesters hold req_go until req_done. The master paces each attempt with m_end.
//
// Ports / modports:
//   master : arbiter view. Its inputs are req_go, req_data, m_end and m_ack.
//            Its outputs are req_done, req_ok, m_go, m_data, busy, grant_id and err_count.
//   slave  : environment view (requesters plus I2C master), with the directions mirrored.
interface i2c_cmd_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 24,
    parameter int CNT_W   = 8
);
    logic [NUM_REQ-1:0]        req_go;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_done;
    logic                      req_ok;
    logic                      m_go;
    logic [DATA_W-1:0]         m_data;
    logic                      m_end;
    logic                      m_ack;
    logic                      busy;
    logic [2:0]                grant_id;
    logic [CNT_W-1:0]          err_count;

    modport master (
        input  req_go, req_data, m_end, m_ack,
        output req_done, req_ok, m_go, m_data, busy, grant_id, err_count
    );

    modport slave (
        output req_go, req_data, m_end, m_ack,
        input  req_done, req_ok, m_go, m_data, busy, grant_id, err_count
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C byte master between NUM_REQ command sources.
// It retries NACKed transfers, applies a per-attempt timeout and returns done/ok status.
// Latency: m_go rises 2 cycles after req_go when the arbiter is idle.
// Backpressure: a request is held until its one-cycle req_done. Each attempt is paced by m_end or the timeout.
//
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : i2c_cmd_arbiter_if.master
//           requests are req_go/req_data; status is req_done/req_ok
//           the master handshake is m_go/m_data/m_end/m_ack
//           observability outputs are busy, grant_id and err_count
module i2c_cmd_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_W      = 24,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 8
) (
    input logic               clk,
    input logic               reset,
    i2c_cmd_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    // One spare code, so the counter stays at least 1 bit wide even when MAX_RETRY is 0.
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_nxt;
    logic [IDX_W-1:0]   grant_q, grant_nxt;
    logic [RTY_W-1:0]   retry_cnt, retry_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               go_q, go_nxt;
    logic [DATA_W-1:0]  data_q, data_nxt;
    logic [CNT_W-1:0]   err_q, err_nxt;
    logic               ok_q, ok_nxt;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    // Slot that sits 'off' positions after 'base' in the ring. base is always < NUM_REQ,
    // so a single conditional subtract gives the wrap.
    function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Pick the first requester at or after rr_ptr. The scan runs from the farthest slot back
    // to the nearest, so the nearest active slot is written last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_go[slot(rr_ptr, k)]) begin
                pick_vld = 1'b1;
                pick_idx = slot(rr_ptr, k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            retry_cnt <= '0;
            timer     <= '0;
            go_q      <= 1'b0;
            data_q    <= '0;
            err_q     <= '0;
            ok_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            grant_q   <= grant_nxt;
            retry_cnt <= retry_nxt;
            timer     <= timer_nxt;
            go_q      <= go_nxt;
            data_q    <= data_nxt;
            err_q     <= err_nxt;
            ok_q      <= ok_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        grant_nxt = grant_q;
        retry_nxt = retry_cnt;
        timer_nxt = timer;
        go_nxt    = go_q;
        data_nxt  = data_q;
        err_nxt   = err_q;
        ok_nxt    = ok_q;

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    // The command is captured here, so later req_data changes cannot reach the master.
                    grant_nxt = pick_idx;
                    data_nxt  = bus.req_data[int'(pick_idx) * DATA_W +: DATA_W];
                    retry_nxt = '0;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                go_nxt    = 1'b1;
                timer_nxt = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                timer_nxt = timer + 1'b1;
                // m_end is checked before the timer, so an end on the expiry cycle still counts.
                if (bus.m_end) begin
                    go_nxt = 1'b0;
                    if (bus.m_ack) begin
                        ok_nxt    = 1'b1;
                        state_nxt = S_DONE;
                    end else if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                        retry_nxt = retry_cnt + 1'b1;
                        state_nxt = S_GAP;
                    end else begin
                        ok_nxt    = 1'b0;
                        state_nxt = S_DONE;
                    end
                end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                    go_nxt    = 1'b0;
                    ok_nxt    = 1'b0;
                    state_nxt = S_DONE;
                end
            end
            S_GAP: begin
                // m_go is low here, which gives the master a falling edge before the retry.
                state_nxt = S_ISSUE;
            end
            S_DONE: begin
                if (!ok_q && (err_q != '1)) err_nxt = err_q + 1'b1;
                rr_nxt    = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_done = '0;
        if (state == S_DONE) bus.req_done[grant_q] = 1'b1;
    end

    assign bus.req_ok    = (state == S_DONE) && ok_q;
    assign bus.m_go      = go_q;
    assign bus.m_data    = data_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.grant_id  = 3'(grant_q);
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Testbench for i2c_cmd_arbiter. A scripted I2C master responder and a transaction-level scoreboard check the DUT.
// Latency: not applicable.
// Backpressure: not applicable. Requesters drop req_go when they see their done pulse.
module tb_i2c_cmd_arbiter;
    localparam int N    = 3;
    localparam int DW   = 24;
    localparam int MR   = 3;
    localparam int TO   = 32;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    i2c_cmd_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW)) bus ();

    i2c_cmd_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .MAX_RETRY(MR), .TIMEOUT_CYC(TO), .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the round-robin pointer and the saturating error count.
    int rr_m  = 0;
    int err_m = 0;

    // Expected transactions, in grant order.
    int            exp_idx[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_ok[$];
    int            exp_att[$];

    // Master responses, one per attempt. A delay of -1 means the master never answers.
    int resp_d[$];
    bit resp_a[$];
    int scr_d[$];
    bit scr_a[$];

    bit mon_en  = 1'b0;
    bit hold    = 1'b0;
    bit go_prev = 1'b0;
    int att     = 0;
    int hi_cnt  = 0;
    int low_cnt = 0;
    int cur_d   = -1;
    bit cur_a   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int first_at(input logic [N-1:0] set, input int ptr);
        int res;
        res = -1;
        for (int k = N - 1; k >= 0; k--) if (set[(ptr + k) % N]) res = (ptr + k) % N;
        return res;
    endfunction

    // Apply the retry/timeout rules to the current script. Queue only the attempts
    // that will actually be used, and record the expected outcome.
    task automatic commit(input int idx, input logic [DW-1:0] dat);
        bit ok;
        bit fin;
        int natt;
        ok = 1'b0;
        fin = 1'b0;
        natt = 0;
        for (int k = 0; k < scr_d.size() && !fin; k++) begin
            resp_d.push_back(scr_d[k]);
            resp_a.push_back(scr_a[k]);
            natt = k + 1;
            if (scr_d[k] < 0) begin ok = 1'b0; fin = 1'b1; end
            else if (scr_a[k]) begin ok = 1'b1; fin = 1'b1; end
            else if (k >= MR) begin ok = 1'b0; fin = 1'b1; end
        end
        exp_idx.push_back(idx);
        exp_data.push_back(dat);
        exp_ok.push_back(ok);
        exp_att.push_back(natt);
        rr_m = (idx + 1) % N;
        scr_d.delete();
        scr_a.delete();
    endtask

    // One clock step: the master responder, the requester reactions and the scoreboard.
    task automatic tick();
        logic [N-1:0] v;
        @(negedge clk);
        if (mon_en) begin
            bus.m_end = 1'b0;
            bus.m_ack = 1'b0;
            if (bus.m_go && !go_prev) begin
                att++;
                if (exp_idx.size() == 0) begin
                    chk("unexpected_m_go", 32'(bus.m_go), 0);
                end else begin
                    chk("m_data", 32'(bus.m_data), 32'(exp_data[0]));
                    chk("grant_id", 32'(bus.grant_id), 32'(exp_idx[0]));
                    chk("busy_wait", 32'(bus.busy), 1);
                    if (att > 1) chk("retry_gap_low", 32'(low_cnt >= 1), 1);
                    if (!hold) begin
                        bus.req_data[exp_idx[0]*DW +: DW] = DW'($urandom);
                        if ($urandom_range(0, 3) == 0) bus.req_go[exp_idx[0]] = 1'b0;
                    end
                end
                if (resp_d.size() == 0) begin
                    chk("resp_underflow", 32'(resp_d.size()), 1);
                    cur_d = -1;
                    cur_a = 1'b0;
                end else begin
                    cur_d = resp_d.pop_front();
                    cur_a = resp_a.pop_front();
                end
                hi_cnt = 0;
            end
            if (bus.m_go) begin
                if (hi_cnt == cur_d) begin
                    bus.m_end = 1'b1;
                    bus.m_ack = cur_a;
                end
                hi_cnt++;
                low_cnt = 0;
            end else begin
                if (go_prev) chk("m_go_high_cycles", 32'(hi_cnt), 32'((cur_d < 0) ? TO : cur_d + 1));
                low_cnt++;
                // Stray m_end pulses outside WAIT must have no effect.
                if ($urandom_range(0, 7) == 0) begin
                    bus.m_end = 1'b1;
                    bus.m_ack = 1'($urandom);
                end
            end
            if (bus.req_done != '0) begin
                if (exp_idx.size() == 0) begin
                    chk("spurious_done", 32'(bus.req_done), 0);
                end else begin
                    v = '0;
                    v[exp_idx[0]] = 1'b1;
                    chk("req_done", 32'(bus.req_done), 32'(v));
                    chk("req_ok", 32'(bus.req_ok), 32'(exp_ok[0]));
                    chk("attempts", 32'(att), 32'(exp_att[0]));
                    chk("err_count", 32'(bus.err_count), 32'(err_m));
                    chk("busy_done", 32'(bus.busy), 1);
                    if (!exp_ok[0] && err_m < CMAX) err_m++;
                    if (!hold) bus.req_go[exp_idx[0]] = 1'b0;
                    void'(exp_idx.pop_front());
                    void'(exp_data.pop_front());
                    void'(exp_ok.pop_front());
                    void'(exp_att.pop_front());
                    att = 0;
                    if (exp_idx.size() == 0) bus.req_go = '0;
                end
            end
            go_prev = bus.m_go;
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_idx.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        if (exp_idx.size() != 0) begin
            chk("drain_budget", 32'(exp_idx.size()), 0);
            exp_idx.delete();
            exp_data.delete();
            exp_ok.delete();
            exp_att.delete();
            bus.req_go = '0;
        end
        repeat (3) tick();
        chk("unused_responses", 32'(resp_d.size()), 0);
        resp_d.delete();
        resp_a.delete();
    endtask

    task automatic launch(input int i, input logic [DW-1:0] dat);
        bus.req_data[i*DW +: DW] = dat;
        bus.req_go[i] = 1'b1;
    endtask

    // mode 0: random responses. mode 1: every attempt NACKed at once.
    task automatic round(input logic [N-1:0] set, input int mode);
        int start;
        start = rr_m;
        for (int k = 0; k < N; k++) begin
            int i;
            logic [DW-1:0] dat;
            i = (start + k) % N;
            if (set[i]) begin
                dat = DW'($urandom);
                for (int a = 0; a <= MR; a++) begin
                    int r;
                    r = int'($urandom_range(0, 9));
                    if (mode == 1) begin
                        scr_d.push_back(0);
                        scr_a.push_back(1'b0);
                    end else if (r == 0) begin
                        scr_d.push_back(-1);
                        scr_a.push_back(1'b0);
                    end else if (r == 1) begin
                        scr_d.push_back(TO - 1);
                        scr_a.push_back(1'($urandom));
                    end else begin
                        scr_d.push_back(int'($urandom_range(0, 12)));
                        scr_a.push_back($urandom_range(0, 2) == 0);
                    end
                end
                commit(i, dat);
                bus.req_data[i*DW +: DW] = dat;
            end
        end
        bus.req_go = bus.req_go | set;
        drain(N * (MR + 1) * (TO + 4) + 50);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        bus.req_go   = '0;
        bus.req_data = '0;
        bus.m_end    = 1'b0;
        bus.m_ack    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_m_go", 32'(bus.m_go), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_err_count", 32'(bus.err_count), 0);
        chk("rst_req_done", 32'(bus.req_done), 0);
        chk("rst_req_ok", 32'(bus.req_ok), 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (2) tick();

        // Round-robin with all requests held continuously: the grants go 0,1,2,0.
        hold = 1'b1;
        d0 = 24'h11_0001;
        d1 = 24'h22_0002;
        d2 = 24'h33_0003;
        for (int k = 0; k < 4; k++) begin
            scr_d.push_back(3 + k);
            scr_a.push_back(1'b1);
            commit(k % 3, (k % 3 == 0) ? d0 : (k % 3 == 1) ? d1 : d2);
        end
        bus.req_data = {d2, d1, d0};
        bus.req_go = '1;
        drain(400);
        hold = 1'b0;

        // Single request: ack in the 20th WAIT cycle. Also check the 2-cycle go latency.
        scr_d.push_back(19);
        scr_a.push_back(1'b1);
        commit(0, 24'h34_001A);
        launch(0, 24'h34_001A);
        tick();
        chk("latency_cycle1_m_go", 32'(bus.m_go), 0);
        tick();
        chk("latency_cycle2_m_go", 32'(bus.m_go), 1);
        drain(200);
        chk("single_err_count", 32'(bus.err_count), 0);

        // NACK, NACK, then ACK on requester 1.
        scr_d.push_back(5);  scr_a.push_back(1'b0);
        scr_d.push_back(7);  scr_a.push_back(1'b0);
        scr_d.push_back(4);  scr_a.push_back(1'b1);
        commit(1, 24'h5A_0C33);
        launch(1, 24'h5A_0C33);
        drain(300);
        chk("nack_ack_err_count", 32'(bus.err_count), 0);

        // Retries exhausted: 4 attempts, then fail.
        round(3'b100, 1);
        chk("exhausted_err_count", 32'(bus.err_count), 1);

        // Timeout with no m_end, then m_end with ack on the expiry cycle.
        scr_d.push_back(-1);
        scr_a.push_back(1'b0);
        commit(2, 24'h77_1234);
        launch(2, 24'h77_1234);
        drain(300);
        scr_d.push_back(TO - 1);
        scr_a.push_back(1'b1);
        commit(0, 24'h08_8888);
        launch(0, 24'h08_8888);
        drain(300);
        chk("timeout_err_count", 32'(bus.err_count), 2);

        for (int r = 0; r < 40; r++) round(N'($urandom_range(1, (1 << N) - 1)), 0);

        // Saturation of the error counter.
        for (int r = 0; r < 260; r++) round(N'(1 << $urandom_range(0, N - 1)), 1);
        chk("err_count_saturated", 32'(bus.err_count), CMAX);

        // Reset during WAIT: finish a grant to 0 so the pointer moves to 1, then grant 1 and reset.
        round(3'b001, 0);
        mon_en = 1'b0;
        bus.m_end = 1'b0;
        bus.m_ack = 1'b0;
        bus.req_data = {d2, d1, d0};
        bus.req_go = 3'b011;
        repeat (2) tick();
        chk("pre_rst_m_go", 32'(bus.m_go), 1);
        chk("pre_rst_grant", 32'(bus.grant_id), 32'(first_at(3'b011, rr_m)));
        repeat (5) tick();
        reset = 1'b0;
        #1;
        chk("midrst_m_go", 32'(bus.m_go), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_grant", 32'(bus.grant_id), 0);
        chk("midrst_m_data", 32'(bus.m_data), 0);
        chk("midrst_req_done", 32'(bus.req_done), 0);
        chk("midrst_req_ok", 32'(bus.req_ok), 0);
        chk("midrst_err_count", 32'(bus.err_count), 0);
        repeat (2) begin
            tick();
            chk("inrst_req_done", 32'(bus.req_done), 0);
        end
        reset = 1'b1;
        tick();
        tick();
        chk("regrant_m_go", 32'(bus.m_go), 1);
        chk("regrant_id", 32'(bus.grant_id), 32'(first_at(3'b011, 0)));
        chk("regrant_m_data", 32'(bus.m_data), 32'(d0));
        bus.m_end = 1'b1;
        bus.m_ack = 1'b1;
        tick();
        bus.m_end = 1'b0;
        bus.m_ack = 1'b0;
        chk("regrant_done", 32'(bus.req_done), 32'(3'b001));
        chk("regrant_ok", 32'(bus.req_ok), 1);
        bus.req_go = '0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares one I2C byte-transfer master (go/end/ack handshake, 24-bit command word: device address, register, data) between up to NUM_REQ command sources.
- Typical sources: the audio codec configuration sequencer, a runtime volume/mute controller and a video decoder configurator.
- Arbitrates round-robin, latches the winning command and drives the master handshake.
- Retries NACKed transfers, enforces a per-transfer timeout and returns a done/ok/fail status to the requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 24, command word width.
- MAX_RETRY, 3, extra attempts after a NACK (0 = no retry).
- TIMEOUT_CYC, 4096, clk cycles allowed in WAIT before abort (≥2).
- CNT_W, 8, width of the error counter.

Ports:
- clk  in  1  system clock (50 kHz I2C control domain)
- reset  in  1  asynchronous, active-low
- req_go  in  NUM_REQ  per-requester request level, held until req_done
- req_data  in  NUM_REQ*DATA_W  requester i command at bits [i*DATA_W +: DATA_W]
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_ok  out  1  valid with req_done; 1 = transfer acknowledged
- m_go  out  1  start request to the I2C master
- m_data  out  DATA_W  command word to the master
- m_end  in  1  master end-of-transfer indication
- m_ack  in  1  master ack result, sampled when m_end=1
- busy  out  1  high in any state other than IDLE
- grant_id  out  3  index of the current or last granted requester
- err_count  out  CNT_W  saturating count of failed commands (NACK after all retries, or timeout)

Behaviour:
- Reset values: req_done=0, req_ok=0, m_go=0, m_data=0, busy=0, grant_id=0, err_count=0, rr_ptr=0, retry_cnt=0, timer=0, state=IDLE. Reset mid-transfer aborts immediately; no done pulse is issued.
- IDLE: if any req_go is high, select the first requester at or after rr_ptr (wrapping modulo NUM_REQ). Latch its req_data into m_data and set grant_id, retry_cnt=0, then go to ISSUE. Request-to-m_go latency is 2 cycles.
- ISSUE: m_go=1, timer=0, go to WAIT.
- WAIT:
  - m_go stays 1 and timer increments each cycle.
  - If m_end=1: drop m_go. With m_ack=1, go to DONE with ok=1. With m_ack=0 and retry_cnt<MAX_RETRY, increment retry_cnt and go to GAP. With m_ack=0 and retries exhausted, go to DONE with ok=0.
  - Else if timer reaches TIMEOUT_CYC-1: drop m_go and go to DONE with ok=0. No retry after a timeout.
  - m_end and timer expiry in the same cycle: m_end wins.
- GAP: one cycle with m_go=0, which gives the master a falling edge to re-arm. Then go to ISSUE with the same latched m_data.
- DONE:
  - Pulse req_done[grant_id] and drive req_ok for exactly one cycle.
  - If ok=0, err_count increments, saturating at all-ones.
  - rr_ptr = grant_id+1 (wrapping); return to IDLE.
- The latched command is immune to req_data changes after grant. If req_go drops mid-transfer, the transfer still completes and the done pulse is still issued.
- A requester must drop req_go in the cycle after req_done. A go still high is a new request, granted only after every other pending requester has had one turn.
- m_end seen outside WAIT is ignored.
- busy=1 in ISSUE, WAIT, GAP and DONE.

Test Plan:
- Single request: req_go[0]=1, data=24'h34_001A, master returns end with ack after 20 cycles → m_go rises 2 cycles after req_go; m_data=34001A; req_done[0] pulses once with req_ok=1; err_count=0.
- Round-robin: req_go=3'b111 held continuously, every transfer acked → grants occur in order 0,1,2,0. Each grant_id is matched by a req_done pulse on the same index.
- NACK then ack: two NACKs, then an ack on req 1 → three m_go assertions, each preceded by ≥1 low cycle; m_data is unchanged throughout; done with ok=1; err_count=0.
- Retries exhausted: MAX_RETRY=3 and every transfer NACKed → 4 attempts; done with ok=0; err_count=1. Repeat 256 times with CNT_W=8 → err_count saturates at 255.
- Timeout: m_end never asserted, TIMEOUT_CYC=16 → m_go is high for exactly 16 cycles, then done with ok=0. Also assert m_end on the expiry cycle with ack=1 → ok=1.
- Reset mid-WAIT: pull reset low during WAIT → m_go=0, busy=0 and all other outputs at reset values immediately; no req_done. After release, a held req_go is re-granted from index 0.
